// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note events onto VOICES engine voices.
// Tracks per-voice keys and LRU ages; one event is scanned, issued and held at a time.
module voice_allocator #(
   parameter int unsigned VOICES  = 8,
   parameter int unsigned V_WIDTH = 3
) (
   input  logic               OSC_CLK,
   input  logic               iRST_N,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_is_on,
   input  logic [7:0]         in_key,
   input  logic [7:0]         in_vel,
   input  logic [VOICES-1:0]  voice_free,
   input  logic               frame_ack,
   output logic [VOICES-1:0]  keys_on,
   output logic               note_on,
   output logic [V_WIDTH-1:0] cur_key_adr,
   output logic [7:0]         cur_key_val,
   output logic [7:0]         cur_vel_on,
   output logic [7:0]         cur_vel_off,
   output logic               stolen,
   output logic [V_WIDTH:0]   active_cnt
);

   typedef enum logic [1:0] {StIdle, StScan, StIssue, StHold} state_e;

   state_e state_q, state_d;

   logic [V_WIDTH-1:0] idx_q;
   logic               is_on_q;
   logic [7:0]         key_q, vel_q;

   // Candidate registers, one per allocation class
   logic               m_found_q, f_found_q, r_found_q;
   logic [V_WIDTH-1:0] m_idx_q, f_idx_q, r_idx_q, o_idx_q;
   logic [V_WIDTH-1:0] r_age_q, o_age_q;

   logic [7:0]         key_tab_q [VOICES];
   logic [V_WIDTH-1:0] age_q     [VOICES];
   logic [VOICES-1:0]  keys_on_q;
   logic               note_on_q, stolen_q;
   logic [V_WIDTH-1:0] cur_key_adr_q;
   logic [7:0]         cur_key_val_q, cur_vel_on_q, cur_vel_off_q;
   logic [V_WIDTH:0]   active_cnt_q;

   logic [V_WIDTH-1:0] tgt;
   logic               pick_o;
   logic               scan_last;
   logic [V_WIDTH:0]   pop_cnt;

   assign scan_last = (idx_q == V_WIDTH'(VOICES - 1));

   always_comb begin
      tgt    = o_idx_q;
      pick_o = 1'b0;
      if (m_found_q) begin
         tgt = m_idx_q;
      end else if (f_found_q) begin
         tgt = f_idx_q;
      end else if (r_found_q) begin
         tgt = r_idx_q;
      end else begin
         pick_o = 1'b1;
      end
   end

   always_comb begin
      pop_cnt = '0;
      for (int v = 0; v < int'(VOICES); v++) begin
         pop_cnt = pop_cnt + (V_WIDTH+1)'(keys_on_q[v]);
      end
   end

   always_ff @(posedge OSC_CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) state_d = StScan;
         end
         StScan:  if (scan_last) state_d = StIssue;
         StIssue: state_d = is_on_q ? StHold : StIdle;
         StHold:  if (frame_ack) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge OSC_CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         idx_q         <= '0;
         is_on_q       <= 1'b0;
         key_q         <= '0;
         vel_q         <= '0;
         m_found_q     <= 1'b0;
         f_found_q     <= 1'b0;
         r_found_q     <= 1'b0;
         m_idx_q       <= '0;
         f_idx_q       <= '0;
         r_idx_q       <= '0;
         o_idx_q       <= '0;
         r_age_q       <= '0;
         o_age_q       <= '0;
         keys_on_q     <= '0;
         note_on_q     <= 1'b0;
         stolen_q      <= 1'b0;
         cur_key_adr_q <= '0;
         cur_key_val_q <= '0;
         cur_vel_on_q  <= '0;
         cur_vel_off_q <= '0;
         active_cnt_q  <= '0;
         for (int v = 0; v < int'(VOICES); v++) begin
            key_tab_q[v] <= '0;
            age_q[v]     <= V_WIDTH'(v);
         end
      end else begin
         stolen_q     <= 1'b0;
         active_cnt_q <= pop_cnt;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  is_on_q   <= in_is_on;
                  key_q     <= in_key;
                  vel_q     <= in_vel;
                  idx_q     <= '0;
                  m_found_q <= 1'b0;
                  f_found_q <= 1'b0;
                  r_found_q <= 1'b0;
                  r_age_q   <= '0;
                  o_age_q   <= '0;
                  o_idx_q   <= '0;
               end
            end
            StScan: begin
               idx_q <= idx_q + V_WIDTH'(1);
               if (!m_found_q && keys_on_q[idx_q] && key_tab_q[idx_q] == key_q) begin
                  m_found_q <= 1'b1;
                  m_idx_q   <= idx_q;
               end
               if (!f_found_q && voice_free[idx_q] && !keys_on_q[idx_q]) begin
                  f_found_q <= 1'b1;
                  f_idx_q   <= idx_q;
               end
               if (!keys_on_q[idx_q] && !voice_free[idx_q] &&
                   (!r_found_q || age_q[idx_q] > r_age_q)) begin
                  r_found_q <= 1'b1;
                  r_idx_q   <= idx_q;
                  r_age_q   <= age_q[idx_q];
               end
               if (idx_q == '0 || age_q[idx_q] > o_age_q) begin
                  o_idx_q <= idx_q;
                  o_age_q <= age_q[idx_q];
               end
            end
            StIssue: begin
               if (is_on_q) begin
                  key_tab_q[tgt] <= key_q;
                  keys_on_q[tgt] <= 1'b1;
                  cur_key_adr_q  <= tgt;
                  cur_key_val_q  <= key_q;
                  cur_vel_on_q   <= vel_q;
                  stolen_q       <= pick_o & keys_on_q[tgt];
                  note_on_q      <= 1'b1;
                  // Younger voices age by one; the target becomes the youngest
                  for (int v = 0; v < int'(VOICES); v++) begin
                     if (age_q[v] < age_q[tgt]) age_q[v] <= age_q[v] + V_WIDTH'(1);
                  end
                  age_q[tgt] <= '0;
               end else if (m_found_q) begin
                  keys_on_q[m_idx_q] <= 1'b0;
                  cur_key_adr_q      <= m_idx_q;
                  cur_vel_off_q      <= vel_q;
               end
            end
            StHold: begin
               if (frame_ack) note_on_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign keys_on     = keys_on_q;
   assign note_on     = note_on_q;
   assign cur_key_adr = cur_key_adr_q;
   assign cur_key_val = cur_key_val_q;
   assign cur_vel_on  = cur_vel_on_q;
   assign cur_vel_off = cur_vel_off_q;
   assign stolen      = stolen_q;
   assign active_cnt  = active_cnt_q;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules incoming MIDI note events onto the synth engine's VOICES polyphonic voices.
- Owns the per-voice key table and LRU ages; produces keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on and cur_vel_off for the synth engine.
- Prefers retrigger, then free voices, then releasing voices, and steals the oldest voice when all are busy.
- Holds each note-on event until the engine confirms a frame latch via frame_ack.

Parameters:
VOICES, 8, number of polyphonic voices
V_WIDTH, 3, log2(VOICES); voice index width

Ports:
OSC_CLK  input  1  system clock
iRST_N  input  1  reset, asynchronous, active-low
in_valid  input  1  note event present
in_ready  output  1  block can accept an event this cycle
in_is_on  input  1  1 = note-on, 0 = note-off
in_key  input  8  MIDI key number
in_vel  input  8  velocity (on or off)
voice_free  input  VOICES  per-voice envelope-idle flags from the envelope generator
frame_ack  input  1  one-cycle pulse: engine latched note_on this frame
keys_on  output  VOICES  per-voice gate
note_on  output  1  note-on event level, held until acknowledged
cur_key_adr  output  V_WIDTH  voice index of the last event
cur_key_val  output  8  key assigned by the last note-on
cur_vel_on  output  8  velocity of the last note-on
cur_vel_off  output  8  velocity of the last matched note-off
stolen  output  1  one-cycle pulse: last note-on stole a gated voice
active_cnt  output  V_WIDTH+1  popcount of keys_on

Behaviour:
- Reset values:
  - keys_on=0, note_on=0, stolen=0, all cur_* = 0, active_cnt=0, in_ready=1.
  - key table = 0; age[v]=v, so voice VOICES-1 is oldest.
  - FSM returns to IDLE. Reset mid-operation discards the pending event.
- FSM states IDLE, SCAN, ISSUE, HOLD.
- IDLE:
  - in_ready=1.
  - in_valid=1 latches in_is_on, in_key and in_vel, clears the candidate registers, and goes to SCAN.
  - in_ready drops the next cycle. Events offered while in_ready=0 are not accepted; the source holds them.
- SCAN visits v=0..VOICES-1, one per cycle (VOICES cycles), sampling voice_free[v] live. For each v it records the first match in each class:
  - M (match): keys_on[v] && key[v]==in_key.
  - F (free): voice_free[v] && !keys_on[v], lowest index.
  - R (releasing): !keys_on[v] && !voice_free[v], largest age.
  - O (oldest): largest age over all voices.
  - Ages are a permutation of 0..VOICES-1, so there are no ties.
- ISSUE (1 cycle), note-on case:
  - Target = M if found, else F, else R, else O.
  - stolen=1 only when the target was chosen as O and keys_on[target] was 1.
  - key[target]<=in_key; keys_on[target]<=1.
  - cur_key_adr, cur_key_val and cur_vel_on are updated.
  - LRU update: every voice with age < age[target] increments; age[target]<=0.
  - note_on<=1; go to HOLD.
- ISSUE, note-off case:
  - If M is found: keys_on[M]<=0, cur_key_adr<=M, cur_vel_off<=in_vel.
  - If M is not found: event dropped, no output change.
  - Ages unchanged; note_on untouched; go to IDLE.
- HOLD:
  - note_on stays 1 and in_ready=0.
  - On frame_ack=1: note_on<=0 the next cycle and FSM goes to IDLE.
  - frame_ack outside HOLD is ignored.
- Latency, event accept to outputs valid:
  - Note-off: VOICES+1 cycles; in_ready again at VOICES+2.
  - Note-on: note_on rises at VOICES+1 and falls 1 cycle after frame_ack.
- cur_* outputs hold their value between events. keys_on changes only in ISSUE. active_cnt is registered and follows keys_on by 1 cycle.
- The all-free, all-gated and retrigger cases all allocate exactly one voice. Retriggering the same key never occupies a second voice.

Test Plan:
- Reset, voice_free=8'hFF, note-on key 60 vel 100 -> ISSUE at cycle 9: cur_key_adr=0, keys_on=8'h01, note_on=1 until frame_ack+1, stolen=0, active_cnt=1.
- Note-ons keys 60..67 with acks -> voices 0..7 allocated, keys_on=8'hFF. Then key 70 -> target voice 0 (oldest), stolen pulse=1, cur_key_val=70.
- Voices 0-2 gated. Note-off key 61 -> keys_on[1]=0, cur_vel_off=in_vel, no note_on. Note-off key 99 -> no change.
- Voice 1 released with voice_free[1]=0, voice 5 free. Note-on -> voice 5 (free beats releasing). Then voice_free=0 and all other voices gated -> voice 1 (releasing).
- Retrigger: key 64 on at voice 3, new note-on key 64 vel 20 -> cur_key_adr=3, cur_vel_on=20, active_cnt unchanged, age[3]=0.
- Assert iRST_N=0 during HOLD -> note_on=0, keys_on=0, in_ready=1 after release. in_valid held during SCAN -> event not accepted until IDLE.
